// File: rtl/nearest_node_finder_if.sv
// Read port toward the XMEM/YMEM decoder.
// One memory select and one address are presented at a time.
interface nearest_node_finder_if #(
    parameter int ADDR_W  = 8,
    parameter int COORD_W = 8
);
    logic [2:0]         mem_id;
    logic [ADDR_W-1:0]  mem_address;
    logic [COORD_W-1:0] mem_data;
    logic               mem_wren;
    logic [COORD_W-1:0] xmem_q;
    logic [COORD_W-1:0] ymem_q;

    modport master (
        output mem_id,
        output mem_address,
        output mem_data,
        output mem_wren,
        input  xmem_q,
        input  ymem_q
    );

    modport slave (
        input  mem_id,
        input  mem_address,
        input  mem_data,
        input  mem_wren,
        output xmem_q,
        output ymem_q
    );
endinterface

// File: rtl/nearest_node_finder.sv
// Finds the stored node nearest (Manhattan) to a query node.
// X and Y are fetched serially through one decoder port.
module nearest_node_finder #(
    parameter int ADDR_W  = 8,
    parameter int COORD_W = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   query_idx,
    input  logic [ADDR_W:0]     node_count,
    nearest_node_finder_if.master bus,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   nearest_idx,
    output logic [COORD_W:0]    nearest_dist,
    output logic                no_match
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_QX_A,
        S_QX_C,
        S_QY_A,
        S_QY_C,
        S_SCAN,
        S_NX_A,
        S_NX_C,
        S_NY_A,
        S_NY_C,
        S_FINISH
    } state_t;

    localparam logic [ADDR_W:0] NMAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_qidx;
    logic [ADDR_W:0]     r_n;
    logic [ADDR_W:0]     r_j;
    logic [COORD_W-1:0]  r_qx;
    logic [COORD_W-1:0]  r_qy;
    logic [COORD_W-1:0]  r_x;
    logic [ADDR_W-1:0]   r_best_idx;
    logic [COORD_W:0]    r_best_dist;
    logic                r_has_best;
    logic                r_busy;
    logic                r_done;
    logic [ADDR_W-1:0]   r_nearest_idx;
    logic [COORD_W:0]    r_nearest_dist;
    logic                r_no_match;
    logic [2:0]          r_mem_id;
    logic [ADDR_W-1:0]   r_mem_addr;

    logic [ADDR_W:0]     w_n_sat;
    logic                w_early;
    logic [COORD_W-1:0]  w_dx;
    logic [COORD_W-1:0]  w_dy;
    logic [COORD_W:0]    w_d;
    logic                w_better;

    assign w_n_sat = (node_count > NMAX) ? NMAX : node_count;
    assign w_early = (w_n_sat == '0) || ({1'b0, query_idx} >= w_n_sat);

    // Y of the candidate is taken straight off the memory in NY_C.
    assign w_dx = (r_qx >= r_x) ? (r_qx - r_x) : (r_x - r_qx);
    assign w_dy = (r_qy >= bus.ymem_q) ? (r_qy - bus.ymem_q)
                                       : (bus.ymem_q - r_qy);
    assign w_d      = {1'b0, w_dx} + {1'b0, w_dy};
    assign w_better = !r_has_best || (w_d < r_best_dist);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_qidx         <= '0;
            r_n            <= '0;
            r_j            <= '0;
            r_qx           <= '0;
            r_qy           <= '0;
            r_x            <= '0;
            r_best_idx     <= '0;
            r_best_dist    <= '0;
            r_has_best     <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_nearest_idx  <= '0;
            r_nearest_dist <= '0;
            r_no_match     <= 1'b0;
            r_mem_id       <= 3'd0;
            r_mem_addr     <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_qidx      <= query_idx;
                        r_n         <= w_n_sat;
                        r_j         <= '0;
                        r_has_best  <= 1'b0;
                        r_best_idx  <= '0;
                        r_best_dist <= '0;
                        r_busy      <= 1'b1;
                        if (w_early) begin
                            r_state        <= S_FINISH;
                            r_done         <= 1'b1;
                            r_no_match     <= 1'b1;
                            r_nearest_idx  <= '0;
                            r_nearest_dist <= '0;
                        end else begin
                            r_state    <= S_QX_A;
                            r_mem_id   <= 3'd0;
                            r_mem_addr <= query_idx;
                        end
                    end
                end
                S_QX_A: r_state <= S_QX_C;
                S_QX_C: begin
                    r_qx     <= bus.xmem_q;
                    r_state  <= S_QY_A;
                    r_mem_id <= 3'd1;
                end
                S_QY_A: r_state <= S_QY_C;
                S_QY_C: begin
                    r_qy       <= bus.ymem_q;
                    r_state    <= S_SCAN;
                    r_mem_id   <= 3'd0;
                    r_mem_addr <= '0;
                end
                S_SCAN: begin
                    if (r_j == r_n) begin
                        r_state        <= S_FINISH;
                        r_done         <= 1'b1;
                        r_nearest_idx  <= r_best_idx;
                        r_nearest_dist <= r_best_dist;
                        r_no_match     <= !r_has_best;
                    end else if (r_j == {1'b0, r_qidx}) begin
                        r_j <= r_j + ONE;
                    end else begin
                        r_state    <= S_NX_A;
                        r_mem_id   <= 3'd0;
                        r_mem_addr <= r_j[ADDR_W-1:0];
                    end
                end
                S_NX_A: r_state <= S_NX_C;
                S_NX_C: begin
                    r_x      <= bus.xmem_q;
                    r_state  <= S_NY_A;
                    r_mem_id <= 3'd1;
                end
                S_NY_A: r_state <= S_NY_C;
                S_NY_C: begin
                    // Strict compare keeps the lowest index on ties.
                    if (w_better) begin
                        r_has_best  <= 1'b1;
                        r_best_idx  <= r_j[ADDR_W-1:0];
                        r_best_dist <= w_d;
                    end
                    r_j        <= r_j + ONE;
                    r_state    <= S_SCAN;
                    r_mem_id   <= 3'd0;
                    r_mem_addr <= '0;
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_id      = r_mem_id;
    assign bus.mem_address = r_mem_addr;
    assign bus.mem_data    = '0;
    assign bus.mem_wren    = 1'b0;

    assign busy         = r_busy;
    assign done         = r_done;
    assign nearest_idx  = r_nearest_idx;
    assign nearest_dist = r_nearest_dist;
    assign no_match     = r_no_match;

endmodule

// File: tb/tb_nearest_node_finder.sv
// Bench for nearest_node_finder: directed and random searches
// against a brute-force model and a per-cycle bus trace.
module tb_nearest_node_finder;
    localparam int AW = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] query_idx = '0;
    logic [AW:0]   node_count = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] nearest_idx;
    logic [CW:0]   nearest_dist;
    logic          no_match;

    nearest_node_finder_if #(.ADDR_W(AW), .COORD_W(CW)) bus ();

    nearest_node_finder #(.ADDR_W(AW), .COORD_W(CW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .query_idx    (query_idx),
        .node_count   (node_count),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .nearest_idx  (nearest_idx),
        .nearest_dist (nearest_dist),
        .no_match     (no_match)
    );

    always #5 clk = ~clk;

    logic [CW-1:0] xmem [256];
    logic [CW-1:0] ymem [256];

    always @(posedge clk) begin
        bus.xmem_q <= xmem[bus.mem_address];
        bus.ymem_q <= ymem[bus.mem_address];
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(int id, int ad, int b, int d);
        return 32'((id << 16) | (ad << 8) | (b << 1) | d);
    endfunction

    function automatic int absd(int a, int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Brute force over all nodes except the query.
    task automatic model(input int q, input int n, output int eidx,
                         output int edist, output bit enm);
        int nsat;
        int best;
        nsat = (n > 256) ? 256 : n;
        best = -1;
        eidx = 0;
        edist = 0;
        enm = 1'b1;
        if (nsat == 0 || q >= nsat) return;
        for (int i = 0; i < nsat; i++) begin
            int d;
            if (i == q) continue;
            d = absd(xmem[q], xmem[i]) + absd(ymem[q], ymem[i]);
            if (best < 0 || d < best) begin
                best = d;
                eidx = i;
            end
        end
        edist = (best < 0) ? 0 : best;
        enm = (best < 0);
    endtask

    task automatic run(input int q, input int n, input bit noise,
                       input int abort_cyc, input string tag);
        logic [31:0] exp[$];
        logic [31:0] obs;
        int nsat;
        int eidx;
        int edist;
        bit enm;
        bit early;
        nsat = (n > 256) ? 256 : n;
        early = (nsat == 0) || (q >= nsat);
        model(q, n, eidx, edist, enm);
        exp = {};
        if (early) begin
            exp.push_back(pk(0, 0, 1, 1));
        end else begin
            exp.push_back(pk(0, q, 1, 0));
            exp.push_back(pk(0, q, 1, 0));
            exp.push_back(pk(1, q, 1, 0));
            exp.push_back(pk(1, q, 1, 0));
            for (int j = 0; j < nsat; j++) begin
                exp.push_back(pk(0, 0, 1, 0));
                if (j != q) begin
                    exp.push_back(pk(0, j, 1, 0));
                    exp.push_back(pk(0, j, 1, 0));
                    exp.push_back(pk(1, j, 1, 0));
                    exp.push_back(pk(1, j, 1, 0));
                end
            end
            exp.push_back(pk(0, 0, 1, 0));
            exp.push_back(pk(0, 0, 1, 1));
        end
        @(negedge clk);
        start = 1'b1;
        query_idx = AW'(q);
        node_count = (AW+1)'(n);
        for (int c = 1; c <= exp.size(); c++) begin
            @(negedge clk);
            obs = {13'd0, bus.mem_id, bus.mem_address, 6'd0, busy, done};
            chk($sformatf("%s_trace_c%0d", tag, c), obs, exp[c-1]);
            if (c == abort_cyc) begin
                #1 reset_n = 1'b0;
                #1;
                chk({tag, "_abort_busy"}, busy, 0);
                chk({tag, "_abort_done"}, done, 0);
                start = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk({tag, "_abort_quiet"}, {busy, done}, 0);
                end
                reset_n = 1'b1;
                return;
            end
            if (noise && c < exp.size()) begin
                start = 1'($urandom);
                query_idx = AW'($urandom);
                node_count = (AW+1)'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        chk({tag, "_no_match"}, no_match, enm);
        if (!early) begin
            chk({tag, "_idx"}, nearest_idx, eidx);
            chk({tag, "_dist"}, nearest_dist, edist);
        end
        chk({tag, "_wren"}, {bus.mem_wren, bus.mem_data}, 0);
        @(negedge clk);
        chk({tag, "_busy_fall"}, {busy, done}, 0);
        chk({tag, "_hold"}, no_match, enm);
    endtask

    task automatic put(input int i, input int x, input int y);
        xmem[i] = CW'(x);
        ymem[i] = CW'(y);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) put(i, $urandom, $urandom);

        reset_n = 1'b0;
        start = 1'b1;
        node_count = 3;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_nm", no_match, 0);
        chk("rst_idx", nearest_idx, 0);
        chk("rst_dist", nearest_dist, 0);
        chk("rst_bus", {bus.mem_id, bus.mem_address, bus.mem_wren}, 0);
        chk("rst_data", bus.mem_data, 0);
        start = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);

        put(0, 10, 10); put(1, 20, 5); put(2, 12, 14);
        run(0, 3, 1'b0, 0, "basic");

        put(0, 0, 0); put(1, 5, 0); put(2, 0, 5);
        run(0, 3, 1'b0, 0, "tie");

        run(0, 0, 1'b0, 0, "n0");
        run(0, 1, 1'b0, 0, "n1");
        run(5, 3, 1'b0, 0, "qbig");

        put(0, 0, 0); put(1, 255, 255);
        run(0, 2, 1'b0, 0, "width");

        put(0, 7, 9); put(1, 100, 3); put(2, 8, 8); put(3, 6, 10);
        run(3, 4, 1'b1, 0, "busy_start");

        run(0, 3, 1'b0, 8, "abort");
        run(0, 3, 1'b0, 0, "after_abort");

        for (int t = 0; t < 8; t++) begin
            int n;
            int q;
            n = $urandom_range(1, 14);
            q = $urandom_range(0, n);
            for (int i = 0; i < n; i++) put(i, $urandom, $urandom);
            run(q, n, 1'($urandom), 0, $sformatf("rnd%0d", t));
        end

        for (int i = 0; i < 256; i++) put(i, $urandom, $urandom);
        run(255, 300, 1'b0, 0, "sat");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
